// File: rtl/axi_lite_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_arbiter_if
//
// Purpose: bundles both requester ports (m0 = instruction fetch, m1 = data
// memory), the busy flag and the AXI4-Lite master channels used by
// axi_lite_mem_arbiter.
//
// Modports:
//   master : arbiter side. Takes requests and drives grants, completions and
//            the AXI4-Lite master channels.
//   slave  : environment side. Drives requests and the AXI4-Lite slave
//            responses.
//
// Signal groups:
//   mX_req/we/addr/wdata/wstrb -> arbiter   request and payload
//   mX_gnt/done/rdata/err      <- arbiter   accept and completion
//   busy                       <- arbiter   transaction in flight
//   m_axi_*                                 AW, W, B, AR and R channels
// ---------------------------------------------------------------------------
interface axi_lite_mem_arbiter_if;

    // Requester 0
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_gnt;
    logic        m0_done;
    logic [31:0] m0_rdata;
    logic        m0_err;

    // Requester 1
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_gnt;
    logic        m1_done;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic        busy;

    // AXI4-Lite write address / data / response
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    // AXI4-Lite read address / data
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_done, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output m1_gnt, m1_done, m1_rdata, m1_err,
        output busy,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_done, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  m1_gnt, m1_done, m1_rdata, m1_err,
        input  busy,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );

endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_arbiter
//
// Purpose: shares one AXI4-Lite master port between two simple request/
// response requesters. It grants one request at a time, captures the
// payload, runs exactly one AXI read (AR/R) or write (AW/W/B), and then
// pulses done to the owning requester.
//
// Parameters:
//   ARB_MODE : 0 = fixed priority (m1 wins a tie)
//              1 = round-robin (the port not granted last wins a tie)
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : requester ports, busy flag and AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axi_lite_mem_arbiter #(
    parameter int ARB_MODE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_lite_mem_arbiter_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Captured request payload
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Control state
    logic        owner_q;
    logic        last_grant_q;
    logic        aw_done_q;
    logic        w_done_q;

    // Per-requester completion state
    logic        done0_q;
    logic        done1_q;
    logic        err0_q;
    logic        err1_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    // Combinational decode
    logic        winner;
    logic        grant;
    logic        sel_we;
    logic        arvalid;
    logic        rready;
    logic        awvalid;
    logic        wvalid;
    logic        bready;
    logic        aw_hs;
    logic        w_hs;
    logic        rd_fire;
    logic        wr_fire;
    logic        resp_err;

    // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    logic        unused_resp_lsb;
    assign unused_resp_lsb = bus.m_axi_rresp[0] ^ bus.m_axi_bresp[0];

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        winner = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            if (ARB_MODE == 0) begin
                winner = 1'b1;
            end else begin
                winner = ~last_grant_q;
            end
        end
    end

    assign grant  = (state == IDLE) && (bus.m0_req || bus.m1_req);
    assign sel_we = winner ? bus.m1_we : bus.m0_we;

    // -----------------------------------------------------------------------
    // Next state and AXI handshake outputs
    // -----------------------------------------------------------------------
    assign aw_hs = awvalid && bus.m_axi_awready;
    assign w_hs  = wvalid  && bus.m_axi_wready;

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;

        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = sel_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (bus.m_axi_arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (bus.m_axi_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                // Each valid drops on its own handshake; both may complete
                // in the same cycle.
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if ((aw_done_q || (~aw_done_q && bus.m_axi_awready)) &&
                    (w_done_q  || (~w_done_q  && bus.m_axi_wready))) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bus.m_axi_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rd_fire  = (state == RD_DATA) && bus.m_axi_rvalid;
    assign wr_fire  = (state == WR_RESP) && bus.m_axi_bvalid;
    assign resp_err = rd_fire ? bus.m_axi_rresp[1] : bus.m_axi_bresp[1];

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
        end else begin
            state <= state_nxt;

            if (grant) begin
                owner_q      <= winner;
                last_grant_q <= winner;
            end

            // Handshake flags only live while in WR_REQ.
            if (state == WR_REQ) begin
                aw_done_q <= aw_done_q | aw_hs;
                w_done_q  <= w_done_q  | w_hs;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            // done is registered, so it pulses in the cycle after the final
            // response handshake, coinciding with the return to IDLE.
            done0_q <= (rd_fire || wr_fire) && !owner_q;
            done1_q <= (rd_fire || wr_fire) &&  owner_q;

            if (rd_fire || wr_fire) begin
                if (owner_q) begin
                    err1_q <= resp_err;
                end else begin
                    err0_q <= resp_err;
                end
            end

            // Only reads update read data; a write leaves it untouched.
            if (rd_fire) begin
                if (owner_q) begin
                    rdata1_q <= bus.m_axi_rdata;
                end else begin
                    rdata0_q <= bus.m_axi_rdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Payload capture (no reset: only meaningful once a grant has loaded it)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (grant) begin
            addr_q  <= winner ? bus.m1_addr  : bus.m0_addr;
            wdata_q <= winner ? bus.m1_wdata : bus.m0_wdata;
            wstrb_q <= winner ? bus.m1_wstrb : bus.m0_wstrb;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.m0_gnt   = grant && !winner;
    assign bus.m1_gnt   = grant &&  winner;
    assign bus.m0_done  = done0_q;
    assign bus.m1_done  = done1_q;
    assign bus.m0_err   = err0_q;
    assign bus.m1_err   = err1_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
    assign bus.busy     = (state != IDLE);

    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = awvalid;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = wvalid;
    assign bus.m_axi_bready  = bready;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
module tb_axi_lite_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // bus1: round-robin DUT, slave driven step by step
    // bus0: fixed-priority DUT, always-ready zero-wait slave
    axi_lite_mem_arbiter_if bus1 ();
    axi_lite_mem_arbiter_if bus0 ();

    axi_lite_mem_arbiter #(.ARB_MODE(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    axi_lite_mem_arbiter #(.ARB_MODE(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    assign bus0.m_axi_arready = 1'b1;
    assign bus0.m_axi_rvalid  = bus0.m_axi_rready;
    assign bus0.m_axi_rdata   = 32'h0000_00F0;
    assign bus0.m_axi_rresp   = 2'b00;
    assign bus0.m_axi_awready = 1'b1;
    assign bus0.m_axi_wready  = 1'b1;
    assign bus0.m_axi_bvalid  = bus0.m_axi_bready;
    assign bus0.m_axi_bresp   = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_owner;
        logic prev_owner;
        checks = 0;
        errors = 0;

        rst_n = 1'b0;
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0; bus1.m0_wstrb = 0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0; bus1.m1_wstrb = 0;
        bus1.m_axi_arready = 0; bus1.m_axi_rvalid = 0; bus1.m_axi_rdata = 0; bus1.m_axi_rresp = 0;
        bus1.m_axi_awready = 0; bus1.m_axi_wready = 0; bus1.m_axi_bvalid = 0; bus1.m_axi_bresp = 0;
        bus0.m0_req = 0; bus0.m0_we = 0; bus0.m0_addr = 0; bus0.m0_wdata = 0; bus0.m0_wstrb = 0;
        bus0.m1_req = 0; bus0.m1_we = 0; bus0.m1_addr = 0; bus0.m1_wdata = 0; bus0.m1_wstrb = 0;

        // Reset state
        cyc();
        cyc();
        mid();
        check("rst_busy",    bus1.busy, 0);
        check("rst_arvalid", bus1.m_axi_arvalid, 0);
        check("rst_awvalid", bus1.m_axi_awvalid, 0);
        check("rst_wvalid",  bus1.m_axi_wvalid, 0);
        check("rst_rready",  bus1.m_axi_rready, 0);
        check("rst_bready",  bus1.m_axi_bready, 0);
        check("rst_m0_done", bus1.m0_done, 0);
        check("rst_m1_done", bus1.m1_done, 0);
        check("rst_m0_err",  bus1.m0_err, 0);
        check("rst_m0_rdata", bus1.m0_rdata, 0);
        check("rst_m1_rdata", bus1.m1_rdata, 0);
        rst_n = 1'b1;
        cyc();

        // m0 read, zero-wait slave
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 32'h0000_0010;
        mid();
        check("rd0_m0_gnt_T", bus1.m0_gnt, 1);
        check("rd0_m1_gnt_T", bus1.m1_gnt, 0);
        check("rd0_busy_T",   bus1.busy, 0);
        cyc();
        bus1.m0_req = 0; bus1.m_axi_arready = 1;
        mid();
        check("rd0_arvalid_T1", bus1.m_axi_arvalid, 1);
        check("rd0_araddr_T1",  bus1.m_axi_araddr, 32'h0000_0010);
        check("rd0_busy_T1",    bus1.busy, 1);
        check("rd0_rready_T1",  bus1.m_axi_rready, 0);
        cyc();
        bus1.m_axi_arready = 0; bus1.m_axi_rvalid = 1;
        bus1.m_axi_rdata = 32'h0010_0093; bus1.m_axi_rresp = 2'b00;
        mid();
        check("rd0_rready_T2",  bus1.m_axi_rready, 1);
        check("rd0_arvalid_T2", bus1.m_axi_arvalid, 0);
        check("rd0_done_T2",    bus1.m0_done, 0);
        cyc();
        bus1.m_axi_rvalid = 0; bus1.m_axi_rdata = 32'hFFFF_FFFF;
        mid();
        check("rd0_done_T3",  bus1.m0_done, 1);
        check("rd0_rdata_T3", bus1.m0_rdata, 32'h0010_0093);
        check("rd0_err_T3",   bus1.m0_err, 0);
        check("rd0_busy_T3",  bus1.busy, 0);
        check("rd0_m1done_T3", bus1.m1_done, 0);
        check("rd0_rready_T3", bus1.m_axi_rready, 0);
        cyc();
        mid();
        check("rd0_done_T4",  bus1.m0_done, 0);
        check("rd0_rdata_T4", bus1.m0_rdata, 32'h0010_0093);

        // m1 write, AW delayed, W immediate
        cyc();
        bus1.m1_req = 1; bus1.m1_we = 1; bus1.m1_addr = 32'h1000_0004;
        bus1.m1_wdata = 32'hDEAD_BEEF; bus1.m1_wstrb = 4'hF;
        mid();
        check("wr1_m1_gnt", bus1.m1_gnt, 1);
        check("wr1_m0_gnt", bus1.m0_gnt, 0);
        cyc();
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m_axi_awready = 0; bus1.m_axi_wready = 1;
        mid();
        check("wr1_awvalid_c1", bus1.m_axi_awvalid, 1);
        check("wr1_wvalid_c1",  bus1.m_axi_wvalid, 1);
        check("wr1_awaddr",     bus1.m_axi_awaddr, 32'h1000_0004);
        check("wr1_wdata",      bus1.m_axi_wdata, 32'hDEAD_BEEF);
        check("wr1_wstrb",      bus1.m_axi_wstrb, 4'hF);
        cyc();
        bus1.m_axi_wready = 0;
        mid();
        check("wr1_awvalid_c2", bus1.m_axi_awvalid, 1);
        check("wr1_wvalid_c2",  bus1.m_axi_wvalid, 0);
        cyc();
        bus1.m_axi_awready = 1;
        mid();
        check("wr1_awvalid_c3", bus1.m_axi_awvalid, 1);
        check("wr1_bready_c3",  bus1.m_axi_bready, 0);
        cyc();
        bus1.m_axi_awready = 0; bus1.m_axi_bvalid = 1; bus1.m_axi_bresp = 2'b00;
        mid();
        check("wr1_awvalid_c4", bus1.m_axi_awvalid, 0);
        check("wr1_bready_c4",  bus1.m_axi_bready, 1);
        check("wr1_done_c4",    bus1.m1_done, 0);
        cyc();
        bus1.m_axi_bvalid = 0;
        mid();
        check("wr1_done_c5",   bus1.m1_done, 1);
        check("wr1_err_c5",    bus1.m1_err, 0);
        check("wr1_rdata_c5",  bus1.m1_rdata, 0);
        check("wr1_m0rdata",   bus1.m0_rdata, 32'h0010_0093);
        check("wr1_m0done_c5", bus1.m0_done, 0);

        // Round-robin with both ports requesting continuously
        cyc();
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 32'h0000_0100;
        bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 32'h0000_0200;
        prev_owner = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2 == 1);
            mid();
            check("rr_m0_gnt", bus1.m0_gnt, !exp_owner);
            check("rr_m1_gnt", bus1.m1_gnt, exp_owner);
            if (i > 0) begin
                check("rr_prev_done", prev_owner ? bus1.m1_done : bus1.m0_done, 1);
                check("rr_prev_rdata", prev_owner ? bus1.m1_rdata : bus1.m0_rdata, 32'hA0 + i - 1);
            end
            cyc();
            bus1.m_axi_arready = 1;
            mid();
            check("rr_araddr", bus1.m_axi_araddr, exp_owner ? 32'h0000_0200 : 32'h0000_0100);
            cyc();
            bus1.m_axi_arready = 0; bus1.m_axi_rvalid = 1; bus1.m_axi_rdata = 32'hA0 + i;
            cyc();
            bus1.m_axi_rvalid = 0;
            if (i == 3) begin
                bus1.m0_req = 0; bus1.m1_req = 0;
            end
            prev_owner = exp_owner;
        end
        mid();
        check("rr_last_done",  bus1.m1_done, 1);
        check("rr_last_rdata", bus1.m1_rdata, 32'hA3);
        check("rr_m0_rdata",   bus1.m0_rdata, 32'hA2);
        check("rr_no_gnt",     bus1.m0_gnt | bus1.m1_gnt, 0);

        // Fixed priority: m1 wins every tie
        cyc();
        bus0.m0_req = 1; bus0.m1_req = 1;
        bus0.m0_addr = 32'h0000_0300; bus0.m1_addr = 32'h0000_0400;
        for (int c = 0; c < 12; c++) begin
            mid();
            check("fp_m0_gnt", bus0.m0_gnt, 0);
            check("fp_m1_gnt", bus0.m1_gnt, (c % 3 == 0));
            cyc();
        end
        bus0.m0_req = 0; bus0.m1_req = 0;

        // Error response on m1 read
        bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 32'h0000_0300;
        mid();
        check("err_m1_gnt", bus1.m1_gnt, 1);
        cyc();
        bus1.m1_req = 0; bus1.m_axi_arready = 1;
        cyc();
        bus1.m_axi_arready = 0; bus1.m_axi_rvalid = 1;
        bus1.m_axi_rresp = 2'b10; bus1.m_axi_rdata = 32'hBAD0_BAD0;
        cyc();
        bus1.m_axi_rvalid = 0; bus1.m_axi_rresp = 2'b00;
        mid();
        check("err_m1_done",  bus1.m1_done, 1);
        check("err_m1_err",   bus1.m1_err, 1);
        check("err_m1_rdata", bus1.m1_rdata, 32'hBAD0_BAD0);
        check("err_m0_done",  bus1.m0_done, 0);
        check("err_m0_err",   bus1.m0_err, 0);
        check("err_m0_rdata", bus1.m0_rdata, 32'hA2);

        // Backpressure: rvalid withheld, m0 waits
        cyc();
        bus1.m1_req = 1; bus1.m1_we = 0; bus1.m1_addr = 32'h0000_0500;
        mid();
        check("bp_m1_gnt", bus1.m1_gnt, 1);
        cyc();
        bus1.m1_req = 0; bus1.m_axi_arready = 1;
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 32'h0000_0600;
        mid();
        check("bp_m0_gnt_ar", bus1.m0_gnt, 0);
        check("bp_arvalid",   bus1.m_axi_arvalid, 1);
        cyc();
        bus1.m_axi_arready = 0;
        for (int w = 0; w < 10; w++) begin
            mid();
            check("bp_rready", bus1.m_axi_rready, 1);
            check("bp_busy",   bus1.busy, 1);
            check("bp_m0_gnt", bus1.m0_gnt, 0);
            cyc();
        end
        bus1.m_axi_rvalid = 1; bus1.m_axi_rdata = 32'h0000_0055;
        mid();
        check("bp_rready_fire", bus1.m_axi_rready, 1);
        check("bp_m0_gnt_fire", bus1.m0_gnt, 0);
        cyc();
        bus1.m_axi_rvalid = 0;
        mid();
        check("bp_m1_done",  bus1.m1_done, 1);
        check("bp_m1_rdata", bus1.m1_rdata, 32'h0000_0055);
        check("bp_m1_err",   bus1.m1_err, 0);
        check("bp_m0_gnt",   bus1.m0_gnt, 1);
        cyc();
        bus1.m0_req = 0; bus1.m_axi_arready = 1;
        mid();
        check("bp_m0_araddr", bus1.m_axi_araddr, 32'h0000_0600);
        cyc();
        bus1.m_axi_arready = 0; bus1.m_axi_rvalid = 1; bus1.m_axi_rdata = 32'h0000_0066;
        cyc();
        bus1.m_axi_rvalid = 0;
        mid();
        check("bp_m0_done",  bus1.m0_done, 1);
        check("bp_m0_rdata", bus1.m0_rdata, 32'h0000_0066);

        // Reset in the middle of an m0 write
        cyc();
        bus1.m0_req = 1; bus1.m0_we = 1; bus1.m0_addr = 32'h2000_0000;
        bus1.m0_wdata = 32'h1234_5678; bus1.m0_wstrb = 4'h3;
        mid();
        check("rw_m0_gnt", bus1.m0_gnt, 1);
        cyc();
        bus1.m0_req = 0; bus1.m0_we = 0;
        bus1.m_axi_awready = 0; bus1.m_axi_wready = 0;
        mid();
        check("rw_awvalid_pre", bus1.m_axi_awvalid, 1);
        check("rw_wvalid_pre",  bus1.m_axi_wvalid, 1);
        rst_n = 1'b0;
        cyc();
        mid();
        check("rw_awvalid", bus1.m_axi_awvalid, 0);
        check("rw_wvalid",  bus1.m_axi_wvalid, 0);
        check("rw_bready",  bus1.m_axi_bready, 0);
        check("rw_busy",    bus1.busy, 0);
        check("rw_m0_done", bus1.m0_done, 0);
        check("rw_m0_rdata", bus1.m0_rdata, 0);
        check("rw_m1_err",  bus1.m1_err, 0);
        rst_n = 1'b1;
        cyc();
        bus1.m0_req = 1; bus1.m1_req = 1; bus1.m0_we = 0; bus1.m1_we = 0;
        mid();
        check("rw_tie_m0_gnt", bus1.m0_gnt, 1);
        check("rw_tie_m1_gnt", bus1.m1_gnt, 0);
        cyc();
        bus1.m0_req = 0; bus1.m1_req = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
